// File: rtl/axil_mem_master.sv
// AXI4-Lite master for the MEM stage: runs one single-beat read or write per
// instruction and reports completion with one-cycle DONE pulses for the hazard unit.
module axil_mem_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    AXIL_EN,
  input  logic                    AXIL_WE,
  input  logic [ADDR_WIDTH-1:0]   AXIL_ADDR,
  input  logic [DATA_WIDTH-1:0]   AXIL_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXIL_WSTRB,
  output logic                    AXIL_DONE_READ,
  output logic                    AXIL_DONE_WRITE,
  output logic [DATA_WIDTH-1:0]   AXIL_RDATA,
  output logic                    AXIL_ERR,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_REQ,
    WRITE_RESP,
    READ_REQ,
    READ_RESP,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    done_read_q, done_read_d;
  logic                    done_write_q, done_write_d;
  logic                    aw_hs, w_hs;

  // AW and W are tracked separately so either channel may complete first.
  assign M_AXI_AWVALID = (state_q == WRITE_REQ) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == WRITE_REQ) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WRITE_RESP);
  assign M_AXI_ARVALID = (state_q == READ_REQ);
  assign M_AXI_RREADY  = (state_q == READ_RESP);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  assign AXIL_DONE_READ  = done_read_q;
  assign AXIL_DONE_WRITE = done_write_q;
  assign AXIL_RDATA      = rdata_q;
  assign AXIL_ERR        = err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    done_read_d  = 1'b0;
    done_write_d = 1'b0;

    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (AXIL_EN) begin
          addr_d  = AXIL_ADDR;
          wdata_d = AXIL_WDATA;
          wstrb_d = AXIL_WSTRB;
          state_d = AXIL_WE ? WRITE_REQ : READ_REQ;
        end
      end
      WRITE_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        if (M_AXI_BVALID) begin
          err_d        = (M_AXI_BRESP != 2'b00);
          done_write_d = 1'b1;
          state_d      = DONE;
        end
      end
      READ_REQ: begin
        if (M_AXI_ARREADY) begin
          state_d = READ_RESP;
        end
      end
      READ_RESP: begin
        if (M_AXI_RVALID) begin
          rdata_d     = M_AXI_RDATA;
          err_d       = (M_AXI_RRESP != 2'b00);
          done_read_d = 1'b1;
          state_d     = DONE;
        end
      end
      // The request seen here belongs to the retiring instruction, so it is never launched.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      done_read_q  <= 1'b0;
      done_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      done_read_q  <= done_read_d;
      done_write_q <= done_write_d;
    end
  end

endmodule

// File: doc/axil_mem_master.md
Name: axil_mem_master

Overview:
- AXI4-Lite master that executes the data-memory access of the instruction in the MEM stage, one transaction per instruction.
- Sits between the MEM stage and the system AXI-Lite interconnect.
- Produces AXIL_DONE_READ / AXIL_DONE_WRITE pulses. The hazard unit combines these with AXIL_EN to hold all pipeline registers while a transaction is outstanding.
- Returns load data and a response-error flag to MEM/WB.

Parameters:
- ADDR_WIDTH, 32, byte address width on both the MEM side and the AXI side.
- DATA_WIDTH, 32, data width. Strobe width is DATA_WIDTH/8.

Ports:
- CLK  input  1  core clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- AXIL_EN  input  1  MEM stage requests an access this cycle.
- AXIL_WE  input  1  1 = write, 0 = read; qualified by AXIL_EN.
- AXIL_ADDR  input  ADDR_WIDTH  access address.
- AXIL_WDATA  input  DATA_WIDTH  store data.
- AXIL_WSTRB  input  DATA_WIDTH/8  store byte enables.
- AXIL_DONE_READ  output  1  one-cycle pulse: read completed.
- AXIL_DONE_WRITE  output  1  one-cycle pulse: write completed.
- AXIL_RDATA  output  DATA_WIDTH  captured read data.
- AXIL_ERR  output  1  response was not OKAY; valid only with a DONE pulse.
- M_AXI_AWADDR  output  ADDR_WIDTH; M_AXI_AWVALID  output  1; M_AXI_AWREADY  input  1.
- M_AXI_WDATA  output  DATA_WIDTH; M_AXI_WSTRB  output  DATA_WIDTH/8; M_AXI_WVALID  output  1; M_AXI_WREADY  input  1.
- M_AXI_BRESP  input  2; M_AXI_BVALID  input  1; M_AXI_BREADY  output  1.
- M_AXI_ARADDR  output  ADDR_WIDTH; M_AXI_ARVALID  output  1; M_AXI_ARREADY  input  1.
- M_AXI_RDATA  input  DATA_WIDTH; M_AXI_RRESP  input  2; M_AXI_RVALID  input  1; M_AXI_RREADY  output  1.

Behaviour:
- Reset (async, RST=1):
  - FSM goes to IDLE.
  - All VALID/READY outputs, DONE pulses and AXIL_ERR are 0.
  - AXIL_RDATA and the AW/W/AR address/data registers are 0.
  - Reset asserted mid-transaction abandons it immediately; no DONE pulse is produced.
- FSM states: IDLE, WRITE_REQ, WRITE_RESP, READ_REQ, READ_RESP, DONE.
- IDLE:
  - AXIL_EN=1 registers address, data and strobe.
  - AXIL_WE=1 goes to WRITE_REQ; otherwise goes to READ_REQ.
  - AWVALID+WVALID, or ARVALID, are high from the next cycle.
- WRITE_REQ:
  - AWVALID and WVALID are independent; each drops the cycle after its own handshake.
  - Internal aw_done / w_done flags track each handshake.
  - When both have handshaken (same cycle or different cycles), go to WRITE_RESP.
  - AWADDR, WDATA and WSTRB stay stable while their VALID is high.
- WRITE_RESP:
  - BREADY=1.
  - On BVALID: capture AXIL_ERR = (BRESP != 2'b00) and go to DONE with AXIL_DONE_WRITE=1.
- READ_REQ:
  - ARVALID held until ARREADY, then go to READ_RESP.
- READ_RESP:
  - RREADY=1.
  - On RVALID: capture RDATA into AXIL_RDATA, capture AXIL_ERR = (RRESP != 2'b00), and go to DONE with AXIL_DONE_READ=1.
- DONE:
  - Lasts exactly one cycle; the DONE pulse and AXIL_ERR are registered outputs asserted only in this state.
  - AXIL_EN is ignored here because the pipeline advances this cycle and the request belongs to the retiring instruction.
  - Always returns to IDLE. A following back-to-back request is sampled there; it stalls correctly because its DONE is 0.
- Output holding:
  - AXIL_RDATA holds its value until the next read capture.
  - AXIL_ERR is cleared in IDLE.
- Latency, zero-wait slave (response one cycle after the address handshake): request sampled in cycle N → AXI handshake N+1 → response N+2 → DONE pulse N+3. Each wait cycle from the slave adds one cycle.
- At most one outstanding transaction. AWPROT/ARPROT are not driven; the interconnect ties them to 0.
- AXIL_WE and address changing while not in IDLE have no effect.
- AXIL_DONE_READ and AXIL_DONE_WRITE are never asserted together.

Test Plan:
- Zero-wait write, ADDR=0x1000_0004, WDATA=0xDEADBEEF, WSTRB=0xF, BRESP=OKAY → AW/W handshake one cycle after EN sample; AXIL_DONE_WRITE high exactly 1 cycle at N+3; AXIL_ERR=0.
- Zero-wait read of 0x2000_0000, slave returns 0x12345678 → AXIL_DONE_READ at N+3; AXIL_RDATA=0x12345678 and held after the pulse.
- Write with WREADY 1 cycle after WVALID and AWREADY 3 cycles after AWVALID → WVALID drops first; AWADDR/WDATA stable throughout; DONE 3 cycles later than the zero-wait case.
- AXIL_EN held high across read (0x0) then write (0x4) → two separate transactions; no launch in the DONE cycle; second request starts from IDLE the cycle after the first DONE.
- Read with RRESP=2'b10 (SLVERR) → AXIL_DONE_READ=1 and AXIL_ERR=1 in the same cycle; AXIL_ERR=0 the next cycle.
- RST pulsed while in READ_RESP → ARVALID/RREADY/DONE all 0 immediately; FSM in IDLE; a new read after release completes normally.
